cnn_core_top: RTL and testbench

//  Single-image CNN inference core.
//  - Captures an 8x8 image of 32-bit signed pixels.
//  - Pipeline: 3x3 valid convolution (fixed kernel) -> ReLU -> 2x2/stride-2 max pool -> sum of pooled map.
//  - Returns one scalar score with a sticky done flag.
//  - Leaf compute block under the multi-core accelerator; one instance per core.

---
 rtl/cnn_core_top.sv | 170 +++++++++++++++++
 tb/tb_cnn_core_top.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cnn_core_top.sv
`default_nettype none
// ============================================================================
// Module   : cnn_core_top
// Purpose  : 8x8 image -> 3x3 conv (fixed kernel) -> ReLU -> 2x2 max pool -> sum.
//            Optional saturating arithmetic via the CNN_SAT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_core_top #(
  parameter int IMG_W  = 8,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [IMG_W*IMG_W*DATA_W-1:0] input_img,
  output logic signed [OUT_W-1:0]       value,
  output logic                          done
);
  localparam int c_co = IMG_W - 2;
  localparam int c_po = c_co / 2;
  localparam int c_cw = $clog2(IMG_W);
  localparam logic [c_cw-1:0] c_co_last = c_cw'(c_co - 1);
  localparam logic [c_cw-1:0] c_po_last = c_cw'(c_po - 1);
`ifdef CNN_SAT_EN
  // Headroom for a full 16x kernel gain before clamping.
  localparam int c_sum_w = OUT_W + 5;
  localparam logic signed [c_sum_w-1:0] c_max_w = c_sum_w'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [c_sum_w-1:0] c_min_w = ~c_max_w;
`else
  localparam int c_sum_w = OUT_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_POOL, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IMG_W*IMG_W*DATA_W-1:0] r_img;
  logic signed [OUT_W-1:0]   r_cbuf [c_co][c_co];
  logic [c_cw-1:0]           r_row;
  logic [c_cw-1:0]           r_col;
  logic signed [OUT_W-1:0]   r_acc;

  logic                      w_capture;
  logic                      w_conv_last;
  logic                      w_pool_last;
  logic signed [DATA_W-1:0]  w_pix [IMG_W][IMG_W];
  logic signed [c_sum_w-1:0] w_row_sum [3];
  logic signed [c_sum_w-1:0] w_conv_sum;
  logic signed [OUT_W-1:0]   w_conv;
  logic signed [OUT_W-1:0]   w_relu;
  logic signed [OUT_W-1:0]   w_m0;
  logic signed [OUT_W-1:0]   w_m1;
  logic signed [OUT_W-1:0]   w_pmax;
  logic signed [OUT_W-1:0]   w_acc_nxt;
  logic [c_cw-1:0]           w_pr0;
  logic [c_cw-1:0]           w_pr1;
  logic [c_cw-1:0]           w_pc0;
  logic [c_cw-1:0]           w_pc1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_conv_last = (r_row == c_co_last) && (r_col == c_co_last);
    w_pool_last = (r_row == c_po_last) && (r_col == c_po_last);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (enable) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV:  if (w_conv_last) w_state_nxt = S_POOL;
      S_POOL:  if (w_pool_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  for (genvar gr = 0; gr < IMG_W; gr++) begin : g_pix_row
    for (genvar gc = 0; gc < IMG_W; gc++) begin : g_pix_col
      assign w_pix[gr][gc] = r_img[DATA_W*(gr*IMG_W+gc) +: DATA_W];
    end
  end

  // Kernel is separable: [1 2 1]^T x [1 2 1], so weight each row then combine.
  for (genvar gi = 0; gi < 3; gi++) begin : g_krow
    logic [c_cw-1:0] w_r;
    assign w_r = r_row + c_cw'(gi);
    assign w_row_sum[gi] = c_sum_w'(w_pix[w_r][r_col])
                         + (c_sum_w'(w_pix[w_r][r_col + c_cw'(1)]) <<< 1)
                         + c_sum_w'(w_pix[w_r][r_col + c_cw'(2)]);
  end

  assign w_conv_sum = w_row_sum[0] + (w_row_sum[1] <<< 1) + w_row_sum[2];

  function automatic logic signed [OUT_W-1:0] smax(input logic signed [OUT_W-1:0] a,
                                                   input logic signed [OUT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_pr0  = {r_row[c_cw-2:0], 1'b0};
  assign w_pr1  = {r_row[c_cw-2:0], 1'b1};
  assign w_pc0  = {r_col[c_cw-2:0], 1'b0};
  assign w_pc1  = {r_col[c_cw-2:0], 1'b1};
  assign w_m0   = smax(r_cbuf[w_pr0][w_pc0], r_cbuf[w_pr0][w_pc1]);
  assign w_m1   = smax(r_cbuf[w_pr1][w_pc0], r_cbuf[w_pr1][w_pc1]);
  assign w_pmax = smax(w_m0, w_m1);

`ifdef CNN_SAT_EN
  logic signed [OUT_W:0] w_acc_wide;
  assign w_conv = (w_conv_sum > c_max_w) ? c_max_w[OUT_W-1:0] :
                  (w_conv_sum < c_min_w) ? c_min_w[OUT_W-1:0] : w_conv_sum[OUT_W-1:0];
  assign w_acc_wide = {r_acc[OUT_W-1], r_acc} + {w_pmax[OUT_W-1], w_pmax};
  // Top two bits disagree only on overflow; clamp toward the true sign.
  assign w_acc_nxt  = (w_acc_wide[OUT_W] == w_acc_wide[OUT_W-1]) ? w_acc_wide[OUT_W-1:0] :
                      {w_acc_wide[OUT_W], {(OUT_W-1){~w_acc_wide[OUT_W]}}};
`else
  assign w_conv    = w_conv_sum;
  assign w_acc_nxt = r_acc + w_pmax;
`endif

  assign w_relu = w_conv[OUT_W-1] ? '0 : w_conv;

  always_ff @(posedge clk) begin
    if (w_capture) r_img <= input_img;
    if (r_state == S_CONV) r_cbuf[r_row][r_col] <= w_relu;
  end

  // r_row/r_col walk the conv grid in CONV, then the pool grid in POOL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
      r_acc <= '0;
      value <= '0;
      done  <= 1'b0;
    end else if (w_capture) begin
      r_row <= '0;
      r_col <= '0;
      r_acc <= '0;
      done  <= 1'b0;
    end else if (r_state == S_CONV) begin
      if (r_col == c_co_last) begin
        r_col <= '0;
        r_row <= w_conv_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else if (r_state == S_POOL) begin
      r_acc <= w_acc_nxt;
      if (r_col == c_po_last) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      if (w_pool_last) begin
        value <= w_acc_nxt;
        done  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_core_top.sv
`default_nettype none
// Testbench for cnn_core_top: directed runs with a queue of expected scores.
module tb_cnn_core_top;
  localparam int IMG_W = 8;
  localparam int NPIX  = IMG_W * IMG_W;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [NPIX*32-1:0]   input_img;
  logic signed [31:0]   value;
  logic                 done;

  int tests = 0;
  int fails = 0;
  logic signed [31:0] sb [$];

  cnn_core_top #(.IMG_W(IMG_W), .DATA_W(32), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .input_img (input_img),
    .value     (value),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic longint fit(input longint x);
`ifdef CNN_SAT_EN
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
`else
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
`endif
  endfunction

  function automatic logic signed [31:0] model(input logic [NPIX*32-1:0] im);
    longint rl [6][6];
    longint cv, m, acc, p;
    logic [31:0] px;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        cv = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            px = im[32*((r+i)*IMG_W + c + j) +: 32];
            p  = longint'($signed(px));
            cv = cv + p * ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
          end
        end
        cv = fit(cv);
        rl[r][c] = (cv < 0) ? 0 : cv;
      end
    end
    acc = 0;
    for (int pr = 0; pr < 3; pr++) begin
      for (int pc = 0; pc < 3; pc++) begin
        m = rl[2*pr][2*pc];
        if (rl[2*pr][2*pc+1]   > m) m = rl[2*pr][2*pc+1];
        if (rl[2*pr+1][2*pc]   > m) m = rl[2*pr+1][2*pc];
        if (rl[2*pr+1][2*pc+1] > m) m = rl[2*pr+1][2*pc+1];
        acc = fit(acc + m);
      end
    end
    return acc[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // poke: cycle at which enable is pulsed mid-run; abort_at: cycle at which reset hits.
  task automatic run(input logic [NPIX*32-1:0] im, input logic signed [31:0] exp_v,
                     input int poke, input int abort_at, input string tag);
    int n;
    logic signed [31:0] e;
    input_img = im;
    sb.push_back(exp_v);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < NPIX; k++) input_img[32*k +: 32] = $urandom;
    chk({tag, " done_low_after_start"}, {31'd0, done}, 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      enable = (n == poke);
      if (n == abort_at) begin
        rst = 1'b0;
        #1;
        chk({tag, " abort_value"}, value, 32'd0);
        chk({tag, " abort_done"}, {31'd0, done}, 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    enable = 1'b0;
    chk({tag, " latency"}, n, 32'd45);
    e = sb.pop_front();
    chk({tag, " value"}, value, e);
  endtask

  initial begin
    logic [NPIX*32-1:0] im;
    rst = 1'b0;
    enable = 1'b0;
    input_img = '0;
    #12;
    chk("reset_value", value, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run({NPIX{32'd1}}, 32'sd144, -1, -1, "ones");
    run('0, 32'sd0, -1, -1, "zeros");
    run({NPIX{32'hFFFFFFFF}}, 32'sd0, -1, -1, "minus_ones");
    im = '0;
    im[32*27 +: 32] = 32'd1;
    run(im, 32'sd9, -1, -1, "impulse");
    run({NPIX{32'd1}}, 32'sd144, 10, -1, "enable_mid_run");

    for (int k = 0; k < NPIX; k++) im[32*k +: 32] = 32'($urandom_range(0, 200)) - 32'd100;
    run(im, model(im), -1, -1, "rand_small");

    repeat (5) @(negedge clk);
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_value", value, model(im));

    run({NPIX{32'd1}}, 32'sd144, -1, 20, "reset_abort");
    run({NPIX{32'd1}}, 32'sd144, -1, -1, "after_abort");

`ifdef CNN_SAT_EN
    run({NPIX{32'h10000000}}, 32'sh7FFFFFFF, -1, -1, "big_sat");
`else
    run({NPIX{32'h10000000}}, 32'sd0, -1, -1, "big_wrap");
`endif

    for (int k = 0; k < NPIX; k++) im[32*k +: 32] = $urandom;
    run(im, model(im), -1, -1, "rand_full");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
